// File: rtl/servo_u2duty_sched.sv
// Four-channel servo command to PWM duty scheduler sharing one multiplier across channels.
// Optional deadzone clamp is enabled with the U2DUTY_DEADZONE_EN macro.
module servo_u2duty_sched #(
    parameter int DUTY_WIDTH = 16,
    parameter int DEADZONE   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync,
    input  logic [DUTY_WIDTH-2:0] half_period,
    input  logic [DUTY_WIDTH-1:0] u0,
    input  logic [DUTY_WIDTH-1:0] u1,
    input  logic [DUTY_WIDTH-1:0] u2,
    input  logic [DUTY_WIDTH-1:0] u3,
    output logic [DUTY_WIDTH-2:0] duty0,
    output logic [DUTY_WIDTH-2:0] duty1,
    output logic [DUTY_WIDTH-2:0] duty2,
    output logic [DUTY_WIDTH-2:0] duty3,
    output logic [3:0]            direction,
    output logic                  busy,
    output logic                  update,
    output logic                  overrun
);

    localparam int DW = DUTY_WIDTH;
    localparam int HW = DUTY_WIDTH - 1;
    localparam int PW = 2 * DUTY_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Two's-complement magnitude; the most negative code maps onto itself (0x8000 -> 0x8000).
    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] val);
        logic [DW-1:0] res;
        if (val[DW-1]) begin
            res = ~val + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [DW-1:0]   snap_u_q [4];
    logic [DW-1:0]   snap_u_d [4];
    logic [HW-1:0]   snap_hp_q, snap_hp_d;
    logic            pvalid_q, pvalid_d;
    logic [1:0]      pch_q, pch_d;
    logic [HW-1:0]   wb_duty_q, wb_duty_d;
    logic            wb_sign_q, wb_sign_d;
    logic [HW-1:0]   sh_duty_q [4];
    logic [HW-1:0]   sh_duty_d [4];
    logic [3:0]      sh_dir_q, sh_dir_d;
    logic [HW-1:0]   duty_q [4];
    logic [HW-1:0]   duty_d [4];
    logic [3:0]      dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            update_q, update_d;
    logic            overrun_q, overrun_d;

    logic [DW-1:0]   sel_u_s;
    logic [DW-1:0]   mag_s;
    logic [PW-1:0]   prod_s;
    logic [HW-1:0]   wb_final_s;
    logic            unused_prod_s;

    // Shared multiplier datapath: magnitude of the selected snapshot channel times half period.
    always_comb begin
        sel_u_s       = snap_u_q[k_q];
        mag_s         = magnitude(sel_u_s);
        prod_s        = PW'(mag_s) * PW'(snap_hp_q);
        unused_prod_s = ^{prod_s[PW-1], prod_s[DW-2:0]};
    end

    // Write-back value, optionally clamping tiny non-zero duties to zero.
    always_comb begin
`ifdef U2DUTY_DEADZONE_EN
        if ((wb_duty_q != {HW{1'b0}}) && (wb_duty_q < HW'(DEADZONE))) begin
            wb_final_s = {HW{1'b0}};
        end else begin
            wb_final_s = wb_duty_q;
        end
`else
        wb_final_s = wb_duty_q;
`endif
    end

`ifndef U2DUTY_DEADZONE_EN
    localparam int UNUSED_DEADZONE = DEADZONE;
`endif

    // Sequencer: snapshot on sync, issue one channel per cycle, drain, then commit.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        snap_u_d  = snap_u_q;
        snap_hp_d = snap_hp_q;
        pvalid_d  = 1'b0;
        pch_d     = pch_q;
        wb_duty_d = wb_duty_q;
        wb_sign_d = wb_sign_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        update_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    snap_u_d[0] = u0;
                    snap_u_d[1] = u1;
                    snap_u_d[2] = u2;
                    snap_u_d[3] = u3;
                    snap_hp_d   = half_period;
                    k_d         = 2'd0;
                    state_d     = CALC;
                end else begin
                    state_d     = IDLE;
                end
            end
            CALC: begin
                pvalid_d  = 1'b1;
                pch_d     = k_q;
                wb_duty_d = prod_s[2*DW-3:DW-1];
                wb_sign_d = sel_u_s[DW-1];
                if (k_q == 2'd3) begin
                    k_d     = 2'd0;
                    state_d = DRAIN;
                end else begin
                    k_d     = k_q + 2'd1;
                end
            end
            DRAIN: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                duty_d   = sh_duty_q;
                dir_d    = sh_dir_q;
                update_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline write-back into the shadow bank one cycle after issue.
    always_comb begin
        sh_duty_d = sh_duty_q;
        sh_dir_d  = sh_dir_q;
        if (pvalid_q) begin
            sh_duty_d[pch_q] = wb_final_s;
            sh_dir_d[pch_q]  = wb_sign_q;
        end else begin
            sh_dir_d = sh_dir_q;
        end
    end

    // Status flags; a sync outside IDLE is dropped and flagged on the following cycle.
    always_comb begin
        busy_d = (state_d != IDLE);
        if (sync && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            snap_hp_q <= {HW{1'b0}};
            pvalid_q  <= 1'b0;
            pch_q     <= 2'd0;
            wb_duty_q <= {HW{1'b0}};
            wb_sign_q <= 1'b0;
            sh_dir_q  <= 4'b0000;
            dir_q     <= 4'b0000;
            busy_q    <= 1'b0;
            update_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_u_q[i]  <= {DW{1'b0}};
                sh_duty_q[i] <= {HW{1'b0}};
                duty_q[i]    <= {HW{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            snap_hp_q <= snap_hp_d;
            pvalid_q  <= pvalid_d;
            pch_q     <= pch_d;
            wb_duty_q <= wb_duty_d;
            wb_sign_q <= wb_sign_d;
            sh_dir_q  <= sh_dir_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            update_q  <= update_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                snap_u_q[i]  <= snap_u_d[i];
                sh_duty_q[i] <= sh_duty_d[i];
                duty_q[i]    <= duty_d[i];
            end
        end
    end

    assign duty0     = duty_q[0];
    assign duty1     = duty_q[1];
    assign duty2     = duty_q[2];
    assign duty3     = duty_q[3];
    assign direction = dir_q;
    assign busy      = busy_q;
    assign update    = update_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_servo_u2duty_sched.sv
// Scoreboard bench for servo_u2duty_sched: directed vectors plus randomized sync traffic.
module tb_servo_u2duty_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync;
    logic [14:0] half_period;
    logic [15:0] u0, u1, u2, u3;
    logic [14:0] duty0, duty1, duty2, duty3;
    logic [3:0]  direction;
    logic        busy, update, overrun;

    servo_u2duty_sched dut (
        .clk(clk), .reset_n(reset_n), .sync(sync), .half_period(half_period),
        .u0(u0), .u1(u1), .u2(u2), .u3(u3),
        .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
        .direction(direction), .busy(busy), .update(update), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [3:0][14:0] d;
        logic [3:0]       dir;
    } exp_t;

    exp_t sbq [$];
    int   ovq [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_m = -100;

    logic [3:0][14:0] exp_duty = '0;
    logic [3:0]       exp_dir  = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Reference: duty = floor(|u| * half_period / 2^15), optional deadzone.
    function automatic logic [14:0] model(input logic [15:0] u, input logic [14:0] hp);
        int unsigned mag, r;
        mag = u[15] ? (32'd65536 - {16'd0, u}) : {16'd0, u};
        r = (mag * {17'd0, hp}) / 32'd32768;
`ifdef U2DUTY_DEADZONE_EN
        if (r != 0 && r < 2) r = 0;
`endif
        return r[14:0];
    endfunction

    function automatic logic [15:0] rand_u();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            default: return r[15:0];
        endcase
    endfunction

    function automatic logic [14:0] rand_hp();
        logic [31:0] r;
        r = $urandom;
        return r[14:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sync = 1'b0;
            u0 = rand_u(); u1 = rand_u(); u2 = rand_u(); u3 = rand_u();
            half_period = rand_hp();
        end
    endtask

    task automatic issue(input logic [14:0] hp, input logic [15:0] a, b, c, d);
        exp_t e;
        logic [15:0] uu [4];
        int m;
        @(negedge clk);
        sync = 1'b1; half_period = hp;
        u0 = a; u1 = b; u2 = c; u3 = d;
        uu[0] = a; uu[1] = b; uu[2] = c; uu[3] = d;
        m = cyc;
        if (m >= last_m + 7) begin
            e.cyc = m + 7;
            for (int i = 0; i < 4; i++) begin
                e.d[i]   = model(uu[i], hp);
                e.dir[i] = uu[i][15];
            end
            sbq.push_back(e);
            last_m = m;
        end else begin
            ovq.push_back(m + 1);
        end
        @(negedge clk);
        sync = 1'b0;
    endtask

    // Monitor: per-cycle comparison of every output against the scoreboard expectation.
    always @(negedge clk) begin
        logic exp_up, exp_ov, exp_busy;
        exp_up = 1'b0; exp_ov = 1'b0; exp_busy = 1'b0;
        if (!reset_n) begin
            sbq.delete();
            ovq.delete();
            exp_duty = '0;
            exp_dir  = 4'b0000;
        end else begin
            if (sbq.size() > 0) begin
                exp_busy = (sbq[0].cyc > cyc) && (sbq[0].cyc - cyc <= 6);
                if (sbq[0].cyc == cyc) begin
                    exp_up   = 1'b1;
                    exp_duty = sbq[0].d;
                    exp_dir  = sbq[0].dir;
                    void'(sbq.pop_front());
                end
            end
            if (ovq.size() > 0 && ovq[0] == cyc) begin
                exp_ov = 1'b1;
                void'(ovq.pop_front());
            end
        end
        chk("update", {31'd0, update}, {31'd0, exp_up});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ov});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("duty0", {17'd0, duty0}, {17'd0, exp_duty[0]});
        chk("duty1", {17'd0, duty1}, {17'd0, exp_duty[1]});
        chk("duty2", {17'd0, duty2}, {17'd0, exp_duty[2]});
        chk("duty3", {17'd0, duty3}, {17'd0, exp_duty[3]});
        chk("direction", {28'd0, direction}, {28'd0, exp_dir});
    end

    initial begin
        reset_n = 1'b0; sync = 1'b0; half_period = 15'd100;
        u0 = 16'h7FFF; u1 = 16'h7FFF; u2 = 16'h7FFF; u3 = 16'h7FFF;
        repeat (3) @(negedge clk);
        chk("rst_duty0", {17'd0, duty0}, 32'd0);
        chk("rst_dir", {28'd0, direction}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        issue(15'd100, 16'h0000, 16'h0000, 16'h0000, 16'h0000); idle(7);
        issue(15'd100, 16'h1000, 16'h1000, 16'h1000, 16'h1000); idle(7);
        issue(15'd100, 16'hF000, 16'hF000, 16'hF000, 16'hF000); idle(7);
        issue(15'd100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); idle(7);
        issue(15'd100, 16'h1000, 16'hF000, 16'hFF00, 16'h1FF0); idle(7);
        issue(15'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000); idle(7);
        issue(15'd100, 16'h0200, 16'h0200, 16'hFE00, 16'h0200); idle(7);

        // Overrun 3 cycles after accept, then syncs at E6 (overrun) and E7 (accepted).
        issue(15'd1000, 16'h4000, 16'hC000, 16'h2000, 16'h6000); idle(1);
        issue(15'd2000, 16'h1111, 16'h2222, 16'h3333, 16'h4444); idle(8);
        issue(15'd500, 16'h4000, 16'hC000, 16'h8000, 16'h0001); idle(4);
        issue(15'd700, 16'h7000, 16'h9000, 16'h0100, 16'h0F00); idle(8);
        issue(15'd300, 16'h2000, 16'hE000, 16'h7FFF, 16'h8001); idle(5);
        issue(15'd900, 16'h3000, 16'hD000, 16'h0800, 16'hF800); idle(8);

        // Reset at E3 of a sequence: outputs clear at once and nothing is committed.
        issue(15'd1234, 16'h5000, 16'hB000, 16'h7000, 16'h9000);
        @(posedge clk); @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_duty0", {17'd0, duty0}, 32'd0);
        chk("midrst_duty3", {17'd0, duty3}, 32'd0);
        chk("midrst_dir", {28'd0, direction}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_m = -100;
        idle(10);
        issue(15'd1234, 16'h5000, 16'hB000, 16'h7000, 16'h9000); idle(7);

        for (int t = 0; t < 40; t++) begin
            issue(rand_hp(), rand_u(), rand_u(), rand_u(), rand_u());
            idle($urandom_range(1, 8));
        end

        idle(12);
        chk("sb_empty", sbq.size(), 32'd0);
        chk("ov_empty", ovq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
